// File: rtl/seg7_pkg.sv
// Shared constants for the multi-digit 7-segment driver: segment patterns,
// the hex-to-segment table and the controller state encoding.
package seg7_pkg;

    // Segment vectors are active low: bit 0 = segment a ... bit 6 = segment g.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_if.sv
// Request/status bundle between application logic and the display driver.
interface seg7_if #(
    parameter int DATA_W = 20
) ();

    logic              load;
    logic [DATA_W-1:0] value;
    logic              dec_mode;
    logic              lz_blank;
    logic              busy;
    logic              done;
    logic              overflow;

    modport master (
        output load, value, dec_mode, lz_blank,
        input  busy, done, overflow
    );

    modport slave (
        input  load, value, dec_mode, lz_blank,
        output busy, done, overflow
    );

endinterface

// File: rtl/seg7_lut.sv
// Combinational 4-bit nibble to active-low 7-segment pattern.
module seg7_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_multi.sv
// Multi-digit 7-segment driver: hex or double-dabble decimal rendering with
// overflow dashes, leading-zero blanking and whole-display blinking.
module seg7_multi
    import seg7_pkg::*;
#(
    parameter int N_DIGITS  = 6,
    parameter int DATA_W    = 20,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_if.slave                 bus,
    input  logic                  blink_en,
    output logic [7*N_DIGITS-1:0] hex_out
);

    localparam int BCD_W   = 4 * N_DIGITS;
    localparam int CNT_W   = $clog2(DATA_W) + 1;
    localparam int BLINK_W = $clog2(BLINK_DIV);

    localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(DATA_W - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    state_t                       state;
    logic                         load_q;
    logic [DATA_W-1:0]            value_q;
    logic                         dec_q;
    logic                         lz_q;
    logic [BCD_W-1:0]             bcd;
    logic [DATA_W-1:0]            bin;
    logic [CNT_W-1:0]             bit_cnt;
    logic                         ovf_acc;
    logic [7*N_DIGITS-1:0]        seg_reg;
    logic                         overflow;
    logic                         done;
    logic [BLINK_W-1:0]           blink_cnt;
    logic                         blink_hidden;

    logic                         accept;
    logic                         ovf_final;
    logic [BCD_W-1:0]             bcd_adj;
    logic [BCD_W-1:0]             hex_digits;
    logic [BCD_W-1:0]             digit_src;
    logic [N_DIGITS-1:0][6:0]     lut_seg;
    logic [7*N_DIGITS-1:0]        next_seg;

    // Requests are registered for one cycle before the FSM acts on them; a
    // pending request blocks a second capture so value_q stays stable.
    assign accept    = bus.load && (state == ST_IDLE) && !load_q;
    assign ovf_final = dec_q && ovf_acc;

    assign bus.busy     = (state != ST_IDLE);
    assign bus.done     = done;
    assign bus.overflow = overflow;

    // NOTE: every variable written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    if (DATA_W >= BCD_W) begin : g_hex_trunc
        assign hex_digits = value_q[BCD_W-1:0];
    end else begin : g_hex_ext
        assign hex_digits = {{(BCD_W - DATA_W){1'b0}}, value_q};
    end

    assign digit_src = dec_q ? bcd : hex_digits;

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_lut
        seg7_lut u_lut (
            .nibble (digit_src[4*i +: 4]),
            .seg    (lut_seg[i])
        );
    end

    // Scan from the top digit down; digit 0 always ends the leading run.
    always_comb begin
        logic leading;
        next_seg = '1;
        leading  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if ((digit_src[4*i +: 4] != 4'd0) || (i == 0)) begin
                leading = 1'b0;
            end
            if (ovf_final) begin
                next_seg[7*i +: 7] = SEG_DASH;
            end else if (lz_q && leading) begin
                next_seg[7*i +: 7] = SEG_BLANK;
            end else begin
                next_seg[7*i +: 7] = lut_seg[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            load_q   <= 1'b0;
            value_q  <= '0;
            dec_q    <= 1'b0;
            lz_q     <= 1'b0;
            bcd      <= '0;
            bin      <= '0;
            bit_cnt  <= '0;
            ovf_acc  <= 1'b0;
            seg_reg  <= '1;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done   <= 1'b0;
            load_q <= accept;
            if (accept) begin
                value_q <= bus.value;
                dec_q   <= bus.dec_mode;
                lz_q    <= bus.lz_blank;
            end

            unique case (state)
                ST_IDLE: begin
                    if (load_q) begin
                        if (dec_q) begin
                            state   <= ST_CONV;
                            bcd     <= '0;
                            bin     <= value_q;
                            bit_cnt <= '0;
                            ovf_acc <= 1'b0;
                        end else begin
                            state <= ST_COMMIT;
                        end
                    end
                end

                ST_CONV: begin
                    // A set top-digit MSB after adjustment is a carry out of the register.
                    {bcd, bin} <= {bcd_adj[BCD_W-2:0], bin, 1'b0};
                    ovf_acc    <= ovf_acc | bcd_adj[BCD_W-1];
                    bit_cnt    <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state <= ST_COMMIT;
                    end
                end

                ST_COMMIT: begin
                    seg_reg  <= next_seg;
                    overflow <= ovf_final;
                    done     <= 1'b1;
                    state    <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // Free-running blink timebase; blink_en only gates the output mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt    <= '0;
            blink_hidden <= !blink_hidden;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign hex_out = (blink_en && blink_hidden) ? {(7*N_DIGITS){1'b1}} : seg_reg;

endmodule

// File: doc/seg7_multi.md
Name: seg7_multi

Overview:
- Parametrised multi-digit 7-segment display driver for N_DIGITS static, active-low displays.
- Accepts a binary value with a load strobe and renders it in hex or decimal.
- Decimal conversion is a sequential shift-add-3 (double dabble) taking DATA_W cycles, with overflow detection, leading-zero blanking and whole-display blinking.
- Sits between application logic (counters, accelerometer readout, scores) and the board's display pins.

Parameters:
- N_DIGITS, 6, number of display digits (1..8).
- DATA_W, 20, width of the binary input value (1..32).
- BLINK_DIV, 25000000, clock cycles per blink half-period (>= 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle request to convert `value`; honoured only while idle.
- value  in  DATA_W  binary value, sampled with `load`.
- dec_mode  in  1  sampled with `load`; 1 = decimal, 0 = hex.
- lz_blank  in  1  1 = blank leading zero digits; sampled with `load`.
- blink_en  in  1  1 = display flashes at the BLINK_DIV rate; live, not sampled.
- busy  out  1  high while a conversion is in flight.
- done  out  1  one-cycle pulse when new segment data is committed.
- overflow  out  1  last decimal value did not fit in N_DIGITS; cleared by the next commit.
- hex_out  out  7*N_DIGITS  digit i at [7i+6:7i], digit 0 least significant; bit 0 = segment a ... bit 6 = segment g; active low.

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state IDLE; seg_reg all ones (display blank); busy=0; done=0; overflow=0; blink counter=0; blink phase=visible.
- State machine, states IDLE, CONV, COMMIT:
  - IDLE: on `load`=1, capture value/dec_mode/lz_blank. Go to CONV if dec_mode=1, else COMMIT.
  - CONV: runs exactly DATA_W cycles. Each cycle: add 3 to every BCD digit >= 5, then shift the BCD:binary register left by 1. Then go to COMMIT.
  - COMMIT: write seg_reg and overflow, pulse done, return to IDLE.
- Latency, with `load` sampled at edge 0:
  - Hex: seg_reg, overflow and done update at edge 2.
  - Decimal: update at edge DATA_W+2.
- Handshake:
  - busy = (state != IDLE).
  - `load` while busy is ignored, with no queueing.
  - `load` on the same edge that COMMIT returns to IDLE is ignored; it must be reasserted.
  - The earliest accepted `load` is the cycle done is high.
- Hex mode:
  - Digit i = value[4i+3:4i]; bits beyond DATA_W read as 0.
  - Nonzero bits above 4*N_DIGITS are ignored; overflow=0.
  - Encoding per nibble, digits 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Decimal mode:
  - BCD register is 4*N_DIGITS bits.
  - overflow is sticky during CONV: set if the MSB of the top digit is 1 at a shift, i.e. a carry leaves the register.
  - On overflow, every digit shows dash 0111111 and lz_blank is ignored.
- Leading-zero blanking:
  - Applies when lz_blank=1, overflow=0, and in either mode.
  - Zero digits above the most significant nonzero digit show 1111111.
  - Digit 0 is never blanked, so value 0 shows a single 0.
- Blink:
  - Counter runs 0..BLINK_DIV-1 continuously from reset; phase toggles on wrap.
  - hex_out = all ones when blink_en=1 and phase=hidden, else seg_reg. This mux is combinational from registers.
  - Changing blink_en does not reset the counter.
- Reset mid-CONV: conversion aborted, display blank, done not pulsed.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_BLANK (7'b1111111) and SEG_DASH (7'b0111111).
  - The 16-entry hex-to-segment constant table.
  - The state encoding for IDLE/CONV/COMMIT.
- Sub-module seg7_lut: purely combinational 4-bit to 7-bit lookup using the package table. Instantiated N_DIGITS times via generate.
- The BCD datapath stays inside seg7_multi.

Test Plan:
All scenarios use N_DIGITS=6, DATA_W=20, BLINK_DIV=4.
1. Hex: load value=0x1A3F5, dec_mode=0, lz_blank=1 -> at edge 2, done=1. Digits 0..5 = 0010010, 0001110, 0110000, 0001000, 1111001, 1111111.
2. Decimal: load 123456, lz_blank=0 -> busy for 21 cycles, done at edge 22. Digits 0..5 = 0000010, 0010010, 0011001, 0110000, 0100100, 1111001; overflow=0.
3. Decimal 0 with lz_blank=1 -> digit 0 = 1000000, digits 1..5 = 1111111. Then load 999999 -> all digits 0010000.
4. Decimal 1000000 -> overflow=1, all six digits 0111111. A following hex load of 0x5 clears overflow to 0.
5. Second `load` pulse at cycle 5 of a CONV -> ignored, exactly one done pulse. Separately, rst_n low at cycle 10 of CONV -> busy=0, hex_out all ones, no done.
6. After committing 42, blink_en=1 -> hex_out alternates 4 cycles showing 42 / 4 cycles all ones. blink_en=0 -> steady display.
